// File: rtl/sa_operand_feeder_pkg.sv
// Shared constants, FSM state type and address helper for the systolic-array operand feeder.
package sa_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 8;
    localparam int LANES      = 5;
    localparam int DEPTH      = 5;
    localparam int ROW_STRIDE = 5;

    localparam int L_W        = $clog2(LANES);
    localparam int K_W        = $clog2(DEPTH);
    localparam int T_W        = $clog2(DEPTH + LANES - 1);
    localparam int DRAIN_LAST = DEPTH + LANES - 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } feeder_state_t;

    // Address of an operand; the sum wraps naturally at ADDR_W bits.
    function automatic logic [ADDR_W-1:0] fetch_addr(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] major,
        input logic [ADDR_W-1:0] minor
    );
        return base + major * ADDR_W'(ROW_STRIDE) + minor;
    endfunction

endpackage

// File: rtl/sa_operand_feeder_if.sv
// Feeder control, memory-read and west-edge output bundle.
interface sa_operand_feeder_if;
    import sa_pkg::*;

    logic                    start;
    logic [ADDR_W-1:0]       base_addr;
    logic                    array_en;
    logic                    busy;
    logic                    done;
    logic                    mem_rd_en;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_rd_data;
    logic [LANES-1:0]        out_valid;
    logic [LANES*DATA_W-1:0] out_data;

    modport master (
        output start, base_addr, array_en, mem_rd_data,
        input  busy, done, mem_rd_en, mem_addr, out_valid, out_data
    );

    modport slave (
        input  start, base_addr, array_en, mem_rd_data,
        output busy, done, mem_rd_en, mem_addr, out_valid, out_data
    );

endinterface

// File: rtl/sa_operand_feeder_skew_lane.sv
// One feeder lane: DEPTH-entry operand bank and its registered, skewed output stage.
module sa_skew_lane
    import sa_pkg::*;
#(
    parameter int LANE_IDX = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [K_W-1:0]    i_wr_k,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_load,
    input  logic [T_W-1:0]    i_t,
    input  logic              i_clear,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    localparam logic signed [T_W+1:0] DEPTH_S = (T_W+2)'(DEPTH);

    logic [DATA_W-1:0]     r_bank [DEPTH];
    logic                  r_valid;
    logic [DATA_W-1:0]     r_data;
    logic signed [T_W+1:0] w_rel;
    logic                  w_hit;
    logic [K_W-1:0]        w_rd_k;

    // Lane i is skewed by i steps: drain step t presents operand k = t - i.
    always_comb begin
        w_rel  = $signed({2'b00, i_t}) - $signed((T_W+2)'(LANE_IDX));
        w_hit  = !w_rel[T_W+1] && (w_rel < DEPTH_S);
        w_rd_k = w_rel[K_W-1:0];
    end

    // Bank write from the delayed fetch tag; contents need no reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_bank[i_wr_k] <= i_wr_data;
        end
    end

    // Registered lane output, updated only on advancing drain steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= {DATA_W{1'b0}};
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= {DATA_W{1'b0}};
        end else if (i_load) begin
            r_valid <= w_hit;
            r_data  <= w_hit ? r_bank[w_rd_k] : {DATA_W{1'b0}};
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/sa_operand_feeder.sv
// Operand feeder: fetches a LANES x DEPTH tile from memory, then drains it skewed into the array.
// Optional SA_FEEDER_TRANSPOSE_EN selects column-major fetch addressing.
module sa_operand_feeder
    import sa_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    sa_operand_feeder_if.slave  feed_if
);

    feeder_state_t           r_state;
    feeder_state_t           w_state_nxt;
    logic [ADDR_W-1:0]       r_base;
    logic [L_W-1:0]          r_lane;
    logic [K_W-1:0]          r_k;
    logic                    r_rd_en;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_tag_v;
    logic [L_W-1:0]          r_tag_lane;
    logic [K_W-1:0]          r_tag_k;
    logic [T_W-1:0]          r_t;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_accept;
    logic                    w_fetch_last;
    logic                    w_drain_step;
    logic                    w_drain_last;
    logic [L_W-1:0]          w_lane_nxt;
    logic [K_W-1:0]          w_k_nxt;
    logic [ADDR_W-1:0]       w_addr_nxt;
    logic [LANES-1:0]        w_valid;
    logic [LANES*DATA_W-1:0] w_data;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a start seen while done is still high is dropped.
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_fetch_last = 1'b0;
        w_drain_step = 1'b0;
        w_drain_last = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (feed_if.start && !r_done) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (r_lane == L_W'(LANES-1) && r_k == K_W'(DEPTH-1)) begin
                    w_fetch_last = 1'b1;
                    w_state_nxt  = ST_FLUSH;
                end else begin
                    w_state_nxt  = ST_FETCH;
                end
            end
            ST_FLUSH: w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (feed_if.array_en) begin
                    w_drain_step = 1'b1;
                    if (r_t == T_W'(DRAIN_LAST)) begin
                        w_drain_last = 1'b1;
                        w_state_nxt  = ST_DONE;
                    end else begin
                        w_state_nxt  = ST_DRAIN;
                    end
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Fetch order: lane fastest, then k.
    always_comb begin
        if (r_lane == L_W'(LANES-1)) begin
            w_lane_nxt = {L_W{1'b0}};
            w_k_nxt    = r_k + K_W'(1);
        end else begin
            w_lane_nxt = r_lane + L_W'(1);
            w_k_nxt    = r_k;
        end
`ifdef SA_FEEDER_TRANSPOSE_EN
        w_addr_nxt = fetch_addr(r_base, ADDR_W'(w_lane_nxt), ADDR_W'(w_k_nxt));
`else
        w_addr_nxt = fetch_addr(r_base, ADDR_W'(w_k_nxt), ADDR_W'(w_lane_nxt));
`endif
    end

    // Read issue plus the one-cycle (lane,k) tag that lines up with returning data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base     <= {ADDR_W{1'b0}};
            r_lane     <= {L_W{1'b0}};
            r_k        <= {K_W{1'b0}};
            r_rd_en    <= 1'b0;
            r_addr     <= {ADDR_W{1'b0}};
            r_tag_v    <= 1'b0;
            r_tag_lane <= {L_W{1'b0}};
            r_tag_k    <= {K_W{1'b0}};
        end else begin
            r_tag_v    <= r_rd_en;
            r_tag_lane <= r_lane;
            r_tag_k    <= r_k;
            if (w_accept) begin
                r_base  <= feed_if.base_addr;
                r_lane  <= {L_W{1'b0}};
                r_k     <= {K_W{1'b0}};
                r_rd_en <= 1'b1;
                r_addr  <= feed_if.base_addr;
            end else if (r_state == ST_FETCH) begin
                if (w_fetch_last) begin
                    r_rd_en <= 1'b0;
                    r_lane  <= {L_W{1'b0}};
                    r_k     <= {K_W{1'b0}};
                end else begin
                    r_lane  <= w_lane_nxt;
                    r_k     <= w_k_nxt;
                    r_addr  <= w_addr_nxt;
                end
            end
        end
    end

    // Drain step counter and busy/done status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_t    <= {T_W{1'b0}};
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_state == ST_DONE) begin
                r_busy <= 1'b0;
            end
            if (r_state == ST_FLUSH) begin
                r_t <= {T_W{1'b0}};
            end else if (w_drain_step && !w_drain_last) begin
                r_t <= r_t + T_W'(1);
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        sa_skew_lane #(.LANE_IDX(gi)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (r_tag_v && (r_tag_lane == L_W'(gi))),
            .i_wr_k    (r_tag_k),
            .i_wr_data (feed_if.mem_rd_data),
            .i_load    (w_drain_step),
            .i_t       (r_t),
            .i_clear   (r_state == ST_DONE),
            .o_valid   (w_valid[gi]),
            .o_data    (w_data[gi*DATA_W +: DATA_W])
        );
    end

    assign feed_if.busy      = r_busy;
    assign feed_if.done      = r_done;
    assign feed_if.mem_rd_en = r_rd_en;
    assign feed_if.mem_addr  = r_addr;
    assign feed_if.out_valid = w_valid;
    assign feed_if.out_data  = w_data;

endmodule

// File: tb/tb_sa_operand_feeder.sv
// Scoreboard bench for sa_operand_feeder; follows SA_FEEDER_TRANSPOSE_EN to pick the address model.
module tb_sa_operand_feeder;
    import sa_pkg::*;

`ifdef SA_FEEDER_TRANSPOSE_EN
    localparam bit TRANSPOSE = 1'b1;
`else
    localparam bit TRANSPOSE = 1'b0;
`endif

    typedef struct {
        logic [4:0]   v;
        logic [159:0] d;
        int           cyc;
    } step_t;

    logic         clk = 1'b0;
    logic         rst;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  mem [256];
    logic [7:0]   addr_q [$];
    step_t        step_q [$];
    int           done_q [$];
    logic [4:0]   prev_v = 5'd0;
    step_t        mon_e;
    int           mon_ec;
    logic [4:0]   snap_v;
    logic [159:0] snap_d;

    sa_operand_feeder_if dut_if ();

    sa_operand_feeder dut (
        .clk     (clk),
        .rst     (rst),
        .feed_if (dut_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: data returned one cycle after the read strobe.
    always @(posedge clk) begin
        if (dut_if.mem_rd_en) dut_if.mem_rd_data <= mem[dut_if.mem_addr];
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [159:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    function automatic logic [7:0] model_addr(input logic [7:0] base, input int lane, input int k);
        int off;
        off = TRANSPOSE ? (lane * ROW_STRIDE + k) : (k * ROW_STRIDE + lane);
        return 8'((int'(base) + off) % 256);
    endfunction

    // Reference: 25 read addresses, 9 skewed drain steps, one done; s is the start edge.
    task automatic push_expect(input logic [7:0] base, input int s, input int stall_at, input bit rand_en);
        step_t e;
        for (int k = 0; k < 5; k++)
            for (int l = 0; l < 5; l++) addr_q.push_back(model_addr(base, l, k));
        for (int t = 0; t < 9; t++) begin
            e.v = 5'd0;
            e.d = 160'd0;
            for (int i = 0; i < 5; i++) begin
                if (t - i >= 0 && t - i < 5) begin
                    e.v[i] = 1'b1;
                    e.d[i*32 +: 32] = mem[model_addr(base, i, t - i)];
                end
            end
            e.cyc = rand_en ? -1 : s + 27 + t + ((stall_at >= 0 && t >= stall_at) ? 3 : 0);
            step_q.push_back(e);
        end
        done_q.push_back(rand_en ? -1 : s + 36 + ((stall_at >= 0) ? 3 : 0));
    endtask

    // Monitor: pops expected reads, drain steps and done as the DUT presents them.
    always @(negedge clk) begin
        if (!rst) begin
            if (dut_if.mem_rd_en) begin
                if (addr_q.size() == 0) unexpected("rd_addr", dut_if.mem_addr);
                else check("rd_addr", dut_if.mem_addr, addr_q.pop_front());
            end
            if (dut_if.out_valid != prev_v && dut_if.out_valid != 5'd0) begin
                if (step_q.size() == 0) unexpected("out_valid", dut_if.out_valid);
                else begin
                    mon_e = step_q.pop_front();
                    check("out_valid", dut_if.out_valid, mon_e.v);
                    check("out_data", dut_if.out_data, mon_e.d);
                    if (mon_e.cyc >= 0) check("step_cycle", cyc, mon_e.cyc);
                end
            end
            if (dut_if.done) begin
                if (done_q.size() == 0) unexpected("done", cyc);
                else begin
                    mon_ec = done_q.pop_front();
                    if (mon_ec >= 0) check("done_cycle", cyc, mon_ec);
                    check("busy_at_done", dut_if.busy, 1'b0);
                end
            end
        end
        prev_v = dut_if.out_valid;
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, dut_if.busy, 1'b0);
        check({tag, "_done"}, dut_if.done, 1'b0);
        check({tag, "_rd_en"}, dut_if.mem_rd_en, 1'b0);
        check({tag, "_addr"}, dut_if.mem_addr, 8'h00);
        check({tag, "_valid"}, dut_if.out_valid, 5'd0);
        check({tag, "_data"}, dut_if.out_data, 160'd0);
    endtask

    // Issue one tile (called at a negedge) and return at the negedge where done is seen.
    task automatic run_tile(input logic [7:0] base, input int stall_at, input bit rand_en, input bit extra_start);
        int s;
        bit seen;
        s = cyc + 1;
        seen = 1'b0;
        push_expect(base, s, stall_at, rand_en);
        dut_if.start = 1'b1;
        dut_if.base_addr = base;
        @(negedge clk);
        dut_if.start = 1'b0;
        check("busy_after_start", dut_if.busy, 1'b1);
        for (int n = 0; n < 200; n++) begin
            if (extra_start && cyc == s + 5) begin
                dut_if.start = 1'b1;
                dut_if.base_addr = 8'h40;
            end else begin
                dut_if.start = 1'b0;
            end
            if (rand_en) dut_if.array_en = ($urandom_range(0, 3) != 0);
            else if (stall_at >= 0 && cyc >= s + 26 + stall_at && cyc <= s + 28 + stall_at) dut_if.array_en = 1'b0;
            else dut_if.array_en = 1'b1;
            if (stall_at >= 0 && cyc == s + 26 + stall_at) begin
                snap_v = dut_if.out_valid;
                snap_d = dut_if.out_data;
            end
            if (stall_at >= 0 && cyc >= s + 27 + stall_at && cyc <= s + 29 + stall_at) begin
                check("stall_valid_frozen", dut_if.out_valid, snap_v);
                check("stall_data_frozen", dut_if.out_data, snap_d);
            end
            if (dut_if.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        dut_if.start = 1'b0;
        dut_if.array_en = 1'b1;
        if (!seen) begin
            unexpected("done_timeout", cyc);
            addr_q.delete();
            step_q.delete();
            done_q.delete();
        end
        check("reads_outstanding", addr_q.size(), 0);
        check("steps_outstanding", step_q.size(), 0);
    endtask

    initial begin
        int s;
        rst = 1'b1;
        dut_if.start = 1'b0;
        dut_if.base_addr = 8'h00;
        dut_if.array_en = 1'b1;
        for (int a = 0; a < 256; a++) mem[a] = 32'(a);
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic tile, mem[a] = a.
        run_tile(8'h00, -1, 1'b0, 1'b0);
        @(negedge clk);

        // Address wrap with random memory.
        for (int a = 0; a < 256; a++) mem[a] = $urandom;
        run_tile(8'hF0, -1, 1'b0, 1'b0);
        @(negedge clk);

        // Three-cycle stall at t = 2.
        run_tile(8'($urandom_range(0, 255)), 2, 1'b0, 1'b0);
        @(negedge clk);

        // Start during FETCH is ignored; then start in the done cycle is ignored too.
        run_tile(8'h10, -1, 1'b0, 1'b1);
        dut_if.start = 1'b1;
        dut_if.base_addr = 8'h77;
        @(negedge clk);
        dut_if.start = 1'b0;
        check("done_cycle_start_busy", dut_if.busy, 1'b0);
        check("done_cycle_start_rd_en", dut_if.mem_rd_en, 1'b0);
        // Back-to-back start one cycle after done.
        run_tile(8'h20, -1, 1'b0, 1'b0);
        @(negedge clk);

        // Random tiles with random array_en.
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < 256; a++) mem[a] = $urandom;
            run_tile(8'($urandom_range(0, 255)), -1, 1'b1, 1'b0);
            @(negedge clk);
        end

        // Reset in the middle of DRAIN (t = 4 visible), then a full tile.
        s = cyc + 1;
        push_expect(8'h33, s, -1, 1'b0);
        dut_if.start = 1'b1;
        dut_if.base_addr = 8'h33;
        @(negedge clk);
        dut_if.start = 1'b0;
        for (int n = 0; n < 100 && cyc != s + 31; n++) @(negedge clk);
        if (cyc != s + 31) unexpected("reset_wait_timeout", cyc);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("midreset");
        addr_q.delete();
        step_q.delete();
        done_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_tile(8'h5A, -1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("final_done_pending", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sa_operand_feeder.md
Name: sa_operand_feeder

Overview:
- Upstream operand stage for the 5x5 systolic array.
- On `start`, fetches a LANES x DEPTH operand tile from the 32-bit local operand memory, starting at `base_addr`, and stores it in per-lane bank registers.
- Then drains the tile into the array's west edge with diagonal skew: lane i is delayed i cycles.
- Mirrors the output-side collector, which writes array results back to memory.

Parameters:
- DATA_W, 32, operand word width
- ADDR_W, 8, memory address width
- LANES, 5, number of array rows fed (one lane per row)
- DEPTH, 5, operands per lane per tile (reduction length K)
- ROW_STRIDE, 5, address distance between consecutive k-rows in memory

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  single-cycle request to feed one tile
- base_addr  in  ADDR_W  tile base address, sampled with `start`
- array_en  in  1  array advance enable; low stalls the drain
- busy  out  1  high from the accepted `start` until `done`
- done  out  1  one-cycle pulse when the tile is fully drained
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after `mem_rd_en`
- out_valid  out  LANES  per-lane valid
- out_data  out  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE.
  - `busy`, `done`, `mem_rd_en`, `out_valid` = 0; `mem_addr` = 0; `out_data` = 0.
  - Counters cleared. Bank contents undefined.
- FSM states: IDLE, FETCH, FLUSH, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `base_addr` and enters FETCH; `busy`=1 from the next cycle.
- FETCH: 25 cycles (LANES*DEPTH).
  - Each cycle: `mem_rd_en`=1, `mem_addr` = base + k*ROW_STRIDE + lane.
  - lane increments fastest (0..LANES-1), then k (0..DEPTH-1).
  - Address arithmetic is ADDR_W-bit, wrapping modulo 2^ADDR_W (0xFE + 3 = 0x01).
  - A (lane,k) tag pipeline, delayed 1 cycle, writes `mem_rd_data` into bank[lane][k].
  - After the last read issues, go to FLUSH.
- FLUSH: one cycle.
  - `mem_rd_en`=0; the final read datum is captured.
  - Then go to DRAIN with t=0.
- DRAIN: drain counter t runs 0..DEPTH+LANES-2 (9 steps).
  - t advances only on cycles with `array_en`=1.
  - Outputs are registered and update only on `array_en`=1 edges.
  - At each update, lane i is loaded as follows:
    - If 0 <= t-i < DEPTH: `out_valid[i]`=1, `out_data` lane i = bank[i][t-i].
    - Otherwise: `out_valid[i]`=0, lane data = 0.
  - `array_en`=0: all outputs and t hold their values (no bubble inserted).
  - After the update for t = DEPTH+LANES-2, go to DONE.
- DONE: one cycle.
  - `done`=1, `busy`=0, `out_valid`=0, `out_data`=0.
  - Then return to IDLE.
  - `start` in the DONE cycle is ignored. Back-to-back minimum: a new `start` one cycle after `done`.
- `start` while `busy`=1 is ignored; `base_addr` is not re-sampled.
- Memory reads are never stalled by `array_en`; only DRAIN stalls.
- Ideal latency (`array_en` tied high):
  - FETCH + FLUSH + DRAIN + DONE = 25+1+9+1 = 36 cycles from the `start` edge to the `done` pulse.
  - First `out_valid[0]` is visible 27 cycles after the `start` edge.

Optional Feature:
- Macro: `SA_FEEDER_TRANSPOSE_EN`.
- Defined: fetch order is column-major, address = base + lane*ROW_STRIDE + k. Used for the B operand, so no transpose is needed in memory.
- Undefined: row-major addressing as above.
- Drain behaviour is identical in both cases.

Decomposition:
- Shared package `sa_pkg`: DATA_W, ADDR_W, LANES, DEPTH, ROW_STRIDE defaults; FSM state enum `feeder_state_t`.
- One natural sub-module, `sa_skew_lane`: one lane's DEPTH-entry bank plus its registered output, parameterised by lane index.

Test Plan:
- Reset mid-DRAIN: assert `rst` at t=4 -> all outputs 0 immediately; FSM in IDLE; a following `start` runs a full correct tile.
- Basic tile: mem[a]=a, base=0x00, `array_en`=1 -> 25 reads at addresses 0..24; then:
  - lane0 emits 0,5,10,15,20 in drain steps t=0..4;
  - lane4 emits 4,9,14,19,24 in steps t=4..8;
  - `done` at cycle 36.
- Address wrap: base=0xF0 -> last read at 0xF0+24 = 0x08; bank[4][4]=mem[0x08].
- Stall: hold `array_en`=0 for 3 cycles at t=2 -> `out_data`/`out_valid` frozen for those 3 cycles; sequence otherwise unchanged; `done` at cycle 39.
- Ignored start: pulse `start` with base=0x40 during FETCH -> no effect on addresses; only one `done`.
- Transpose build: `SA_FEEDER_TRANSPOSE_EN` defined, base=0 -> lane1 emits 5,6,7,8,9.
